// File: rtl/mem_word_responder.sv
// mem_word_responder: single-outstanding req/gnt/rvalid responder in front of a
// byte-enabled word RAM, with programmable grant and response wait states and
// an error response for addresses outside the mapped window.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no transaction; waiting for req_i
// S_GWAIT | req_i seen, counting grant wait states (drop of req_i aborts)
// S_GRANT | gnt_o high; request sampled, RAM accessed on this edge
// S_RWAIT | access done, counting response wait states
// S_RESP  | rvalid_o high with rdata_o/error_o; back to S_IDLE next
module mem_word_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int          GNT_WAIT    = 0,
    parameter int          RESP_WAIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        error_o
);

    localparam int          LP_AW        = $clog2(DEPTH_WORDS);
    // Span in bytes is kept 33 bits wide so a window reaching 4 GiB still compares correctly.
    localparam logic [32:0] LP_SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LP_GNT_LOAD  = (GNT_WAIT  > 0) ? 4'(GNT_WAIT  - 1) : 4'd0;
    localparam logic [3:0]  LP_RESP_LOAD = (RESP_WAIT > 0) ? 4'(RESP_WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GWAIT = 3'd1,
        S_GRANT = 3'd2,
        S_RWAIT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_gnt;
    logic               r_rvalid;
    logic               r_error;
    logic [31:0]        r_rdata;
    logic               r_err_lat;

    // RAM powers up cleared; reset deliberately leaves contents alone.
    logic [31:0]        r_mem [DEPTH_WORDS] = '{default: 32'h0};

    logic [31:0]        w_offset;
    logic               w_in_range;
    logic [LP_AW-1:0]   w_idx;
    logic               w_do_write;

    // Address decode: unsigned offset from the window base, so addresses below
    // the base wrap to large values and fail the range compare.
    always_comb begin
        w_offset   = addr_i - BASE_ADDR;
        w_in_range = ({1'b0, w_offset} < LP_SPAN);
        w_idx      = w_offset[LP_AW+1:2];
        w_do_write = !reset && (r_state == S_GRANT) && we_i && w_in_range;
    end

    // Handshake FSM with registered outputs; gnt/rvalid/error are set on the
    // edge that enters GRANT/RESP so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_gnt     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_error   <= 1'b0;
            r_rdata   <= 32'h0;
            r_err_lat <= 1'b0;
        end else begin
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        if (GNT_WAIT == 0) begin
                            r_state <= S_GRANT;
                            r_gnt   <= 1'b1;
                        end else begin
                            r_state <= S_GWAIT;
                            r_cnt   <= LP_GNT_LOAD;
                        end
                    end
                end
                S_GWAIT: begin
                    if (!req_i) begin
                        // Initiator withdrew before grant: abandon silently.
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_GRANT;
                        r_gnt   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_GRANT: begin
                    r_err_lat <= !w_in_range;
                    if (!we_i && w_in_range) begin
                        r_rdata <= r_mem[w_idx];
                    end else begin
                        r_rdata <= 32'h0;
                    end
                    if (RESP_WAIT == 0) begin
                        r_state  <= S_RESP;
                        r_rvalid <= 1'b1;
                        r_error  <= !w_in_range;
                    end else begin
                        r_state <= S_RWAIT;
                        r_cnt   <= LP_RESP_LOAD;
                    end
                end
                S_RWAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_RESP;
                        r_rvalid <= 1'b1;
                        r_error  <= r_err_lat;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Byte-enabled RAM write at the GRANT edge; kept out of the reset branch
    // so a reset never disturbs stored data.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign gnt_o    = r_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign error_o  = r_error;

endmodule

// File: doc/mem_word_responder.md
# mem_word_responder

Word-wide memory responder that serves the memory side of the core-facing cache: it answers the req/gnt/rvalid handshake with a byte-enabled single-port RAM behind it. It accepts one transaction at a time and inserts programmable grant and response wait states so the cache can be exercised against slow memory. It flags out-of-range addresses with an error response. It sits where external or on-chip data memory attaches to the cache's `mem_*` ports.

## Interface

Parameters:

- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 2.
- `BASE_ADDR`, default 32'h0010_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `GNT_WAIT`, default 0: extra cycles between first sampling `req_i` and asserting `gnt_o`; range 0–15.
- `RESP_WAIT`, default 0: extra cycles between grant and `rvalid_o`; range 0–15.

Ports:

- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous reset, active-high.
- `req_i` input 1: request from initiator.
- `addr_i` input 32: byte address; bits [1:0] are ignored.
- `we_i` input 1: 1 = write, 0 = read.
- `be_i` input 4: byte enables for writes; bit n selects byte n, i.e. bits [8n+7:8n].
- `wdata_i` input 32: write data.
- `gnt_o` output 1: request accepted this cycle.
- `rvalid_o` output 1: response valid, one-cycle pulse.
- `rdata_o` output 32: read data; qualified by `rvalid_o`.
- `error_o` output 1: response is an error; qualified by `rvalid_o`.

## Operation

States:

- **IDLE.**
  - `req_i`=1 and `GNT_WAIT`=0 → GRANT.
  - `req_i`=1 and `GNT_WAIT`>0 → GWAIT, with the wait counter loaded to `GNT_WAIT`-1.
  - Otherwise stay in IDLE.
- **GWAIT.**
  - If `req_i` drops, go to IDLE. This is a protocol violation: no access, no response.
  - Otherwise count down; at 0 → GRANT.
- **GRANT.**
  - `gnt_o`=1 combinationally from state.
  - On this edge, latch `addr_i`, `we_i`, `be_i`, `wdata_i` and perform the access.
  - `RESP_WAIT`=0 → RESP; otherwise → RWAIT, with the counter loaded to `RESP_WAIT`-1.
- **RWAIT.** Count down; at 0 → RESP.
- **RESP.** `rvalid_o`=1 → IDLE unconditionally.

Access rules:

- **Range check.** `offset = addr_i - BASE_ADDR`, computed 32-bit unsigned. The access is in range iff `offset < DEPTH_WORDS*4`. Word index = `offset[log2(DEPTH_WORDS)+1:2]`.
- **In-range write.** Only the enabled bytes are updated; the others are preserved. `be_i`=0 changes nothing and still completes normally. Response: `rdata_o`=0, `error_o`=0.
- **In-range read.** The word is registered into `rdata_o` at the GRANT edge and held until the next access. Response has `error_o`=0.
- **Out-of-range access.** No RAM write. `rdata_o`=0, `error_o`=1 in RESP.
- **RAM contents.** Zero at time 0. Reset does not clear the RAM.

## Timing

- **Outputs under reset.** While `reset` is high and in the cycle after it is released: `gnt_o`=0, `rvalid_o`=0, `error_o`=0, `rdata_o`=0, state=IDLE, counters=0.
- **Reset mid-transaction.** Any granted-but-unanswered transaction is dropped (no `rvalid_o`). A write performed at its GRANT edge stays written.
- **Latency.** With `req_i` first high in cycle 0 and held:
  - `gnt_o` is high in cycle 1+`GNT_WAIT`.
  - `rvalid_o` is high in cycle 2+`GNT_WAIT`+`RESP_WAIT`.
- **Throughput.** Minimum 3 cycles per transaction. `gnt_o` and `rvalid_o` are never high in the same cycle.
- **Single outstanding transaction.** `req_i` is ignored in GRANT+1 through RESP. A `req_i` held high through RESP is sampled again in the following IDLE cycle.
- **Initiator contract.** The initiator holds `addr_i`, `we_i`, `be_i`, `wdata_i` and `req_i` stable until `gnt_o`. The responder samples them only in the GRANT cycle.
- **Read-after-write.** A read granted after a write to the same word returns the merged value.

## Test plan

- **Read after reset, zero waits.** With `GNT_WAIT`=`RESP_WAIT`=0, read `BASE_ADDR`+8 → `gnt_o` in cycle 1, `rvalid_o` in cycle 2, `rdata_o`=0, `error_o`=0.
- **Byte-enabled write, then read.** Write 32'hDEADBEEF with `be_i`=4'b1111 to `BASE_ADDR`+4. Write 32'h0000_00AA with `be_i`=4'b0001 to the same address. Read back → 32'hDEADBEAA. A write with `be_i`=0 leaves the value unchanged.
- **Out-of-range access.** Address `BASE_ADDR`+`DEPTH_WORDS*4` and address `BASE_ADDR`-4 → `rvalid_o` with `error_o`=1 and `rdata_o`=0. A write to these addresses does not alias into word 0; reading word 0 is unchanged.
- **Wait states.** With `GNT_WAIT`=3 and `RESP_WAIT`=2, `req_i` high at cycle 0 → `gnt_o` only in cycle 4, `rvalid_o` only in cycle 7. Dropping `req_i` in cycle 2 gives no grant and no response, and the block returns to IDLE.
- **Back-to-back requests.** Hold `req_i` high for 3 reads → grants in cycles 1, 4, 7 and rvalids in cycles 2, 5, 8. The signals never overlap and no request is lost.
- **Reset mid-transaction.** Assert `reset` in the cycle after a write's grant with `RESP_WAIT`=4 → no `rvalid_o` and all outputs 0. After release, a read of that address returns the written data.
